ryu_motion_ctrl: RTL and testbench

RYU_MOTION_CTRL -- requirements
Module: ryu_motion_ctrl

---
 rtl/ryu_motion_ctrl.sv | 95 +++++++++
 tb/tb_ryu_motion_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ryu_motion_ctrl.sv
// ryu_motion_ctrl: frame-paced walk and punch sequencer for the Ryu sprite
module ryu_motion_ctrl #(
   parameter logic [9:0] START_X    = 10'd100,
   parameter logic [9:0] Y_GROUND   = 10'd300,
   parameter logic [9:0] X_MAX      = 10'd456,
   parameter logic [9:0] STEP       = 10'd4,
   parameter logic [3:0] T_STARTUP  = 4'd3,
   parameter logic [3:0] T_ACTIVE   = 4'd4,
   parameter logic [3:0] T_RECOVERY = 4'd6
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_punch,
   output logic [9:0] RyuX,
   output logic [9:0] RyuY,
   output logic       punch_on,
   output logic       hit_active,
   output logic [1:0] anim_state
);
   typedef enum logic [1:0] {IDLE = 2'b00, STARTUP = 2'b01, ACTIVE = 2'b10, RECOVERY = 2'b11} state_t;
   state_t state;
   logic [3:0] cnt;
   logic key_prev, armed, punch_req, edge_det, req;
   logic [10:0] x_right;
   logic [9:0] x_walk;
   // armed stays low until key_punch is seen released, so a key held through reset is ignored
   assign edge_det = key_punch & ~key_prev & armed;
   assign req      = punch_req | edge_det;
   assign x_right  = {1'b0, RyuX} + {1'b0, STEP};
   assign RyuY       = Y_GROUND;
   assign anim_state = state;
   always_comb
      x_walk = (key_left && !key_right) ? ((RyuX < STEP) ? 10'd0 : RyuX - STEP) :
               (key_right && !key_left) ? ((x_right > {1'b0, X_MAX}) ? X_MAX : x_right[9:0]) :
               RyuX;
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         key_prev   <= 1'b0;
         armed      <= 1'b0;
         punch_req  <= 1'b0;
         RyuX       <= START_X;
         punch_on   <= 1'b0;
         hit_active <= 1'b0;
      end else begin
         key_prev <= key_punch;
         armed    <= armed | ~key_punch;
         if (!frame_tick)
            punch_req <= req;
         else begin
            punch_req <= 1'b0;
            case (state)
               IDLE:
                  if (req) begin
                     state    <= STARTUP;
                     cnt      <= T_STARTUP - 4'd1;
                     punch_on <= 1'b1;
                  end else
                     RyuX <= x_walk;
               STARTUP:
                  if (cnt != 4'd0)
                     cnt <= cnt - 4'd1;
                  else begin
                     state      <= ACTIVE;
                     cnt        <= T_ACTIVE - 4'd1;
                     hit_active <= 1'b1;
                  end
               ACTIVE:
                  if (cnt != 4'd0)
                     cnt <= cnt - 4'd1;
                  else begin
                     state      <= RECOVERY;
                     cnt        <= T_RECOVERY - 4'd1;
                     hit_active <= 1'b0;
                  end
               RECOVERY:
                  if (cnt != 4'd0) begin
                     cnt       <= cnt - 4'd1;
                     punch_req <= req;
                  end else if (req) begin
                     state <= STARTUP;
                     cnt   <= T_STARTUP - 4'd1;
                  end else begin
                     state    <= IDLE;
                     punch_on <= 1'b0;
                  end
               default: state <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// tb_ryu_motion_ctrl: scoreboard bench, expected frame results queued by stimulus and checked by a monitor
module tb_ryu_motion_ctrl;
   logic vga_clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
   logic key_left = 1'b0, key_right = 1'b0, key_punch = 1'b0;
   logic [9:0] RyuX, RyuY;
   logic punch_on, hit_active;
   logic [1:0] anim_state;
   int n_chk = 0, n_fail = 0;
   typedef struct {logic [9:0] x; logic [1:0] a;} exp_t;
   exp_t sb[$];

   ryu_motion_ctrl dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .key_left(key_left), .key_right(key_right), .key_punch(key_punch),
      .RyuX(RyuX), .RyuY(RyuY), .punch_on(punch_on), .hit_active(hit_active),
      .anim_state(anim_state)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick(input logic [9:0] x, input logic [1:0] a, input logic press);
      exp_t e;
      e.x = x;
      e.a = a;
      @(negedge vga_clk);
      sb.push_back(e);
      frame_tick = 1'b1;
      if (press) key_punch = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      if (press) key_punch = 1'b0;
      repeat (2) @(negedge vga_clk);
   endtask

   function automatic logic [1:0] phase(input int i);
      return (i < 3) ? 2'b01 : (i < 7) ? 2'b10 : 2'b11;
   endfunction

   task automatic part(input int lo, input int hi, input logic [9:0] x);
      for (int i = lo; i < hi; i++) tick(x, phase(i), 1'b0);
   endtask

   task automatic press_pulse();
      @(negedge vga_clk);
      key_punch = 1'b1;
      @(negedge vga_clk);
      key_punch = 1'b0;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge vga_clk);
         if (frame_tick && reset_n) begin
            @(negedge vga_clk);
            if (sb.size() == 0) begin
               chk("scoreboard_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("RyuX", 32'(RyuX), 32'(e.x));
               chk("RyuY", 32'(RyuY), 32'd300);
               chk("anim_state", 32'(anim_state), 32'(e.a));
               chk("punch_on", 32'(punch_on), 32'(e.a != 2'b00));
               chk("hit_active", 32'(hit_active), 32'(e.a == 2'b10));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge vga_clk);
      chk("reset_RyuX", 32'(RyuX), 32'd100);
      chk("reset_RyuY", 32'(RyuY), 32'd300);
      chk("reset_anim", 32'(anim_state), 32'd0);
      chk("reset_punch_on", 32'(punch_on), 32'd0);
      chk("reset_hit", 32'(hit_active), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge vga_clk);
      key_right = 1'b1;
      for (int i = 1; i <= 10; i++) tick(10'(100 + 4 * i), 2'b00, 1'b0);
      key_left = 1'b1;
      for (int i = 0; i < 5; i++) tick(10'd140, 2'b00, 1'b0);
      key_left = 1'b0;
      key_right = 1'b0;
      tick(10'd140, 2'b00, 1'b0);
      key_right = 1'b1;
      for (int i = 1; i <= 79; i++) tick(10'(140 + 4 * i), 2'b00, 1'b0);
      tick(10'd456, 2'b00, 1'b0);
      tick(10'd456, 2'b00, 1'b0);
      key_right = 1'b0;
      key_left = 1'b1;
      for (int i = 1; i <= 114; i++) tick(10'(456 - 4 * i), 2'b00, 1'b0);
      tick(10'd0, 2'b00, 1'b0);
      tick(10'd0, 2'b00, 1'b0);
      key_left = 1'b0;
      key_right = 1'b1;
      for (int i = 1; i <= 5; i++) tick(10'(4 * i), 2'b00, 1'b0);
      // single punch with key_right still held: position must not move
      press_pulse();
      repeat (3) @(negedge vga_clk);
      chk("midframe_anim", 32'(anim_state), 32'd0);
      chk("midframe_punch_on", 32'(punch_on), 32'd0);
      part(0, 13, 10'd20);
      tick(10'd20, 2'b00, 1'b0);
      key_right = 1'b0;
      press_pulse();
      part(0, 10, 10'd20);
      press_pulse();
      part(10, 13, 10'd20);
      part(0, 13, 10'd20);
      tick(10'd20, 2'b00, 1'b0);
      press_pulse();
      part(0, 5, 10'd20);
      press_pulse();
      part(5, 13, 10'd20);
      tick(10'd20, 2'b00, 1'b0);
      tick(10'd20, 2'b00, 1'b0);
      tick(10'd20, 2'b01, 1'b1);
      part(1, 13, 10'd20);
      tick(10'd20, 2'b00, 1'b0);
      @(negedge vga_clk);
      key_punch = 1'b1;
      part(0, 4, 10'd20);
      @(negedge vga_clk);
      reset_n = 1'b0;
      #1;
      chk("async_RyuX", 32'(RyuX), 32'd100);
      chk("async_anim", 32'(anim_state), 32'd0);
      chk("async_punch_on", 32'(punch_on), 32'd0);
      chk("async_hit", 32'(hit_active), 32'd0);
      @(negedge vga_clk);
      reset_n = 1'b1;
      tick(10'd100, 2'b00, 1'b0);
      tick(10'd100, 2'b00, 1'b0);
      key_punch = 1'b0;
      @(negedge vga_clk);
      tick(10'd100, 2'b00, 1'b0);
      press_pulse();
      tick(10'd100, 2'b01, 1'b0);
      repeat (4) @(negedge vga_clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
